// File: rtl/vga_sync_module.sv
// VGA timing generator: free-running line/frame counters with registered
// sync, active-video qualifier, active-area coordinates and frame-start pulse.
module vga_sync_module #(
   parameter int unsigned H_SYNC  = 120,
   parameter int unsigned H_BACK  = 64,
   parameter int unsigned H_ACT   = 800,
   parameter int unsigned H_FRONT = 56,
   parameter int unsigned V_SYNC  = 6,
   parameter int unsigned V_BACK  = 23,
   parameter int unsigned V_ACT   = 600,
   parameter int unsigned V_FRONT = 37,
   parameter logic        HS_POL  = 1'b1,
   parameter logic        VS_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        hsync,
   output logic        vsync,
   output logic        ready,
   output logic [10:0] c1,
   output logic [10:0] c2,
   output logic        frame_start
);

   localparam int unsigned CW      = 11;
   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
   localparam int unsigned H_OFS   = H_SYNC + H_BACK;
   localparam int unsigned V_OFS   = V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
   localparam logic [CW-1:0] H_OFS_C  = CW'(H_OFS);
   localparam logic [CW-1:0] V_OFS_C  = CW'(V_OFS);
   localparam logic [CW-1:0] H_END_C  = CW'(H_OFS + H_ACT);
   localparam logic [CW-1:0] V_END_C  = CW'(V_OFS + V_ACT);

   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          ready_q, ready_d;
   logic [CW-1:0] c1_q, c1_d;
   logic [CW-1:0] c2_q, c2_d;
   logic          frame_start_q, frame_start_d;
   logic          h_wrap;
   logic          h_act;
   logic          v_act;

   // Counter advance and output decode, all from the current counter values.
   always_comb begin
      h_wrap        = (h_cnt_q == H_LAST);
      h_cnt_d       = h_wrap ? '0 : h_cnt_q + CW'(1);
      v_cnt_d       = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end

      h_act         = (h_cnt_q >= H_OFS_C) && (h_cnt_q < H_END_C);
      v_act         = (v_cnt_q >= V_OFS_C) && (v_cnt_q < V_END_C);

      hsync_d       = (h_cnt_q < H_SYNC_C) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt_q < V_SYNC_C) ? VS_POL : ~VS_POL;
      ready_d       = h_act && v_act;
      c1_d          = ready_d ? (h_cnt_q - H_OFS_C) : '0;
      c2_d          = ready_d ? (v_cnt_q - V_OFS_C) : '0;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         ready_q       <= 1'b0;
         c1_q          <= '0;
         c2_q          <= '0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         ready_q       <= ready_d;
         c1_q          <= c1_d;
         c2_q          <= c2_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign ready       = ready_q;
   assign c1          = c1_q;
   assign c2          = c2_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_module.md
# vga_sync_module

Timing generator for the VGA path: free-running horizontal/vertical counters producing hsync/vsync, an active-video qualifier, and the active-area pixel coordinates `c1` (column) and `c2` (row). These feed the pixel stage (`vga_control_2`), which turns the coordinates into ROM addresses and rgb. Default timing is 800x600 @ 72 Hz from a 50 MHz pixel clock.

## Interface
- `H_SYNC`, 120: hsync pulse width, clocks
- `H_BACK`, 64: horizontal back porch, clocks
- `H_ACT`, 800: active pixels per line
- `H_FRONT`, 56: horizontal front porch, clocks
- `V_SYNC`, 6: vsync pulse width, lines
- `V_BACK`, 23: vertical back porch, lines
- `V_ACT`, 600: active lines per frame
- `V_FRONT`, 37: vertical front porch, lines
- `HS_POL`, 1: hsync asserted level (1 = active-high)
- `VS_POL`, 1: vsync asserted level
- `clk` in 1: pixel clock, 50 MHz
- `rst_n` in 1: asynchronous, active-low reset
- `hsync` out 1: horizontal sync, registered
- `vsync` out 1: vertical sync, registered
- `ready` out 1: high while (c1,c2) is an active pixel
- `c1` out 11: active column 0..H_ACT-1; 0 when `ready`=0
- `c2` out 11: active row 0..V_ACT-1; 0 when `ready`=0
- `frame_start` out 1: one-clock pulse at line 0, clock 0 of each frame

## Operation
- Definitions: H_TOTAL = H_SYNC+H_BACK+H_ACT+H_FRONT (1040); V_TOTAL = sum of V_* (666). H_OFS = H_SYNC+H_BACK (184); V_OFS = V_SYNC+V_BACK (29).
- Internal `h_cnt` (11 bit) increments every clock and wraps H_TOTAL-1 -> 0.
- Internal `v_cnt` (11 bit) increments only on the clock where `h_cnt` wraps, and wraps V_TOTAL-1 -> 0 on that same clock.
- Line layout in `h_cnt`: [0, H_SYNC) sync, [H_SYNC, H_OFS) back porch, [H_OFS, H_OFS+H_ACT) active, rest front porch. `v_cnt` uses the same layout in lines.
- `hsync` = HS_POL when h_cnt < H_SYNC, otherwise ~HS_POL. `vsync` = VS_POL when v_cnt < V_SYNC, otherwise ~VS_POL. vsync edges coincide with h_cnt = 0.
- `ready` = h_cnt in active range AND v_cnt in active range.
- When `ready`: c1 = h_cnt - H_OFS, c2 = v_cnt - V_OFS (11-bit unsigned, no overflow for legal parameters). Otherwise both are 0.
- `frame_start` = (h_cnt==0 && v_cnt==0).
- Legal parameters: every value ≥ 1, H_TOTAL ≤ 2047, V_TOTAL ≤ 2047. Behaviour outside this range is undefined.

## Timing
- All outputs are registered from the counter values, so they lag the counters by exactly 1 clock. `hsync`, `vsync`, `ready`, `c1`, `c2` and `frame_start` stay mutually aligned.
- Reset (asynchronous assert):
  - h_cnt = 0, v_cnt = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - ready = 0, c1 = 0, c2 = 0, frame_start = 0.
- Reset release: the first rising edge loads outputs for counters (0,0), so hsync, vsync and frame_start assert on that edge. Counters then advance.
- Reset asserted mid-frame: all outputs return to reset values immediately. The frame restarts from (0,0) with no partial-line carryover.
- Wrap: at h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, both counters go to 0 on the same edge. No extra or missing clock per line; the frame period is exactly H_TOTAL*V_TOTAL clocks (692,640).
- Downstream pipeline delays are the consumer's responsibility. This block adds no compensation.

## Test plan
- Reset release: hold rst_n=0 for 5 clocks -> hsync=0, vsync=0, ready=0, c1=c2=0, frame_start=0. On the first edge after release -> hsync=1, vsync=1, frame_start=1 for exactly 1 clock.
- Line timing: measure hsync -> high for 120 clocks, period 1040. ready high for 800 consecutive clocks per active line, beginning 184 clocks after the hsync rising edge.
- Coordinates: on the first ready clock of the first active line -> c1=0, c2=0. On the last ready clock of the frame -> c1=799, c2=599. c1 increments by 1 each ready clock.
- Frame timing: vsync high for 6 lines (6240 clocks). frame_start pulses spaced exactly 692,640 clocks apart over 3 frames. Exactly 600 lines contain ready.
- Mid-frame reset: assert rst_n=0 asynchronously at line 300, column ~400 -> outputs go to reset values without waiting for a clock edge. After release the next frame_start occurs on the first edge and the timing checks above pass.
- Parameter/polarity override: HS_POL=0, VS_POL=0 with 640x480 timing (96/48/640/16, 2/33/480/10) -> hsync low for 96 of 800 clocks, vsync low for 2 of 525 lines, c1 max 639, c2 max 479.
